// File: rtl/uno_seq.sv
// Operation sequencer for the uno MAC/div/exp/log datapath: turns requests into the
// per-cycle uno control stream, holds the Horner coefficient tables, returns one result per request.
module uno_seq #(
  parameter int MAC_BW  = 12,
  parameter int DEG     = 4,
  parameter int MAC_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [MAC_BW-1:0]     req_x,
  input  logic [MAC_BW-1:0]     req_y,
  input  logic [2*MAC_BW-1:0]   req_z,
  input  logic                  req_last,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_op,
  input  logic [2:0]            cfg_idx,
  input  logic [MAC_BW-1:0]     cfg_data,
  output logic                  cfg_err,
  output logic [1:0]            uno_op,
  output logic [MAC_BW-1:0]     uno_x,
  output logic [MAC_BW-1:0]     uno_y,
  output logic [2*MAC_BW-1:0]   uno_z,
  output logic [MAC_BW-1:0]     uno_coeff,
  output logic                  uno_first_cycle,
  output logic                  uno_last_cycle,
  output logic                  uno_acc_en,
  input  logic [2*MAC_BW-1:0]   uno_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*MAC_BW-1:0]   rsp_data
);

  localparam int RW   = 2 * MAC_BW;
  localparam int KMAX = (DEG + 1 > MAC_LAT) ? DEG + 1 : MAC_LAT;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int IW   = $clog2(DEG + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [1:0]        op_q, op_d;
  logic [MAC_BW-1:0] x_q, x_d, y_q, y_d;
  logic              req_ready_q, req_ready_d;
  logic [1:0]        uno_op_q, uno_op_d;
  logic [MAC_BW-1:0] uno_x_q, uno_x_d, uno_y_q, uno_y_d, uno_coeff_q, uno_coeff_d;
  logic [RW-1:0]     uno_z_q, uno_z_d;
  logic              first_q, first_d, last_q, last_d, acc_en_q, acc_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]     rsp_data_q, rsp_data_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cfg_ok;
  logic [KW-1:0]     cidx;
  logic              hs;

  logic [MAC_BW-1:0] coef_q [4][DEG+1];

  assign hs   = req_valid & req_ready_q;
  assign cidx = KW'(DEG) - k_q;
  // A table may not change while it is being walked by the running op.
  assign cfg_ok = (cfg_op != 2'b00) && (int'(cfg_idx) <= DEG) &&
                  !((state_q == S_ISSUE) && (cfg_op == op_q));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    uno_op_d    = 2'b00;
    uno_x_d     = '0;
    uno_y_d     = '0;
    uno_z_d     = '0;
    uno_coeff_d = '0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    acc_en_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    cfg_err_d   = cfg_we & ~cfg_ok;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          k_d = '0;
          if (req_op != 2'b00) begin
            op_d    = req_op;
            x_d     = req_x;
            y_d     = req_y;
            state_d = S_ISSUE;
          end else begin
            uno_x_d = req_x;
            uno_y_d = req_y;
            uno_z_d = req_z;
            state_d = req_last ? S_DRAIN : S_STREAM;
          end
        end
      end
      S_ISSUE: begin
        uno_op_d = op_q;
        uno_x_d  = x_q;
        uno_y_d  = y_q;
        first_d  = (k_q == '0);
        last_d   = (k_q == KW'(DEG + 1));
        if (k_q <= KW'(DEG)) uno_coeff_d = coef_q[op_q][cidx[IW-1:0]];
        if (k_q == KW'(DEG + 1)) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_STREAM: begin
        // Empty cycles become zero-product bubbles so the accumulator holds.
        acc_en_d = 1'b1;
        if (req_valid) begin
          uno_x_d = req_x;
          uno_y_d = req_y;
          if (req_last) begin
            k_d     = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (k_q == KW'(MAC_LAT)) begin
          rsp_data_d  = uno_result;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE) || (state_d == S_STREAM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      req_ready_q <= 1'b0;
      uno_op_q    <= '0;
      uno_x_q     <= '0;
      uno_y_q     <= '0;
      uno_z_q     <= '0;
      uno_coeff_q <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      acc_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      req_ready_q <= req_ready_d;
      uno_op_q    <= uno_op_d;
      uno_x_q     <= uno_x_d;
      uno_y_q     <= uno_y_d;
      uno_z_q     <= uno_z_d;
      uno_coeff_q <= uno_coeff_d;
      first_q     <= first_d;
      last_q      <= last_d;
      acc_en_q    <= acc_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
    x_q  <= x_d;
    y_q  <= y_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < 4; o++)
        for (int i = 0; i <= DEG; i++)
          coef_q[o][i] <= '0;
    end else if (cfg_we && cfg_ok) begin
      coef_q[cfg_op][cfg_idx] <= cfg_data;
    end
  end

  assign req_ready       = req_ready_q;
  assign cfg_err         = cfg_err_q;
  assign uno_op          = uno_op_q;
  assign uno_x           = uno_x_q;
  assign uno_y           = uno_y_q;
  assign uno_z           = uno_z_q;
  assign uno_coeff       = uno_coeff_q;
  assign uno_first_cycle = first_q;
  assign uno_last_cycle  = last_q;
  assign uno_acc_en      = acc_en_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;

endmodule

// File: tb/tb_uno_seq.sv
// Directed bench for uno_seq with a small behavioural uno datapath model.
module tb_uno_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_last;
  logic [1:0]  req_op;
  logic [11:0] req_x, req_y;
  logic [23:0] req_z;
  logic        cfg_we, cfg_err;
  logic [1:0]  cfg_op;
  logic [2:0]  cfg_idx;
  logic [11:0] cfg_data;
  logic [1:0]  uno_op;
  logic [11:0] uno_x, uno_y, uno_coeff;
  logic [23:0] uno_z, uno_result;
  logic        uno_first_cycle, uno_last_cycle, uno_acc_en;
  logic        rsp_valid, rsp_ready;
  logic [23:0] rsp_data;

  int n_assert = 0;
  int n_fail   = 0;

  uno_seq #(.MAC_BW(12), .DEG(4), .MAC_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_last(req_last),
    .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_err(cfg_err),
    .uno_op(uno_op), .uno_x(uno_x), .uno_y(uno_y), .uno_z(uno_z),
    .uno_coeff(uno_coeff), .uno_first_cycle(uno_first_cycle),
    .uno_last_cycle(uno_last_cycle), .uno_acc_en(uno_acc_en),
    .uno_result(uno_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Uno stand-in, one cycle of latency: MAC accumulates x*y+z, poly ops do acc*2+coeff.
  logic [23:0] acc;
  always_ff @(posedge clk) begin
    if (uno_op == 2'b00)
      acc <= (uno_acc_en ? acc : 24'd0) + 24'(uno_x) * 24'(uno_y) + uno_z;
    else if (uno_first_cycle)
      acc <= 24'(uno_coeff);
    else
      acc <= (acc << 1) + 24'(uno_coeff);
  end
  assign uno_result = acc;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge in IDLE; ec[k*12 +: 12] is the coefficient expected at step k.
  task automatic run_poly(input logic [1:0] op, input logic [11:0] x, input logic [71:0] ec,
                          input logic [23:0] exp_rsp, input bit do_cfg, input logic [1:0] c_op,
                          input logic [2:0] c_idx, input logic [11:0] c_data, input bit c_err);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = 12'h003; req_z = '0; req_last = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("poly_req_ready_low", 32'(req_ready), 32'd0);
    if (do_cfg) begin
      cfg_we = 1'b1; cfg_op = c_op; cfg_idx = c_idx; cfg_data = c_data;
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (do_cfg && k == 0) begin
        cfg_we = 1'b0;
        chk("cfg_err_during_issue", 32'(cfg_err), 32'(c_err));
      end
      if (do_cfg && k == 1) chk("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
      chk($sformatf("coeff_k%0d", k), 32'(uno_coeff), 32'(ec[k*12 +: 12]));
      chk($sformatf("first_k%0d", k), 32'(uno_first_cycle), 32'(k == 0));
      chk($sformatf("last_k%0d", k), 32'(uno_last_cycle), 32'(k == 5));
      chk($sformatf("uno_op_k%0d", k), 32'(uno_op), 32'(op));
      chk($sformatf("uno_x_k%0d", k), 32'(uno_x), 32'(x));
    end
    tick();
    chk("drain_no_rsp", 32'(rsp_valid), 32'd0);
    chk("drain_idle_op", 32'(uno_op), 32'd0);
    tick();
    chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    chk("poly_rsp_data", 32'(rsp_data), 32'(exp_rsp));
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_z = '0;
    req_last = 1'b0; cfg_we = 1'b0; cfg_op = '0; cfg_idx = '0; cfg_data = '0; rsp_ready = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_uno_first", 32'(uno_first_cycle), 32'd0);
    chk("rst_uno_coeff", 32'(uno_coeff), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Program exp table c[2][i] = i+1
    for (int i = 0; i < 5; i++) begin
      cfg_we = 1'b1; cfg_op = 2'b10; cfg_idx = 3'(i); cfg_data = 12'(i + 1);
      tick();
      chk($sformatf("cfg_exp_ok_%0d", i), 32'(cfg_err), 32'd0);
    end
    cfg_we = 1'b0;

    // Exp: coefficients 5,4,3,2,1,0 -> 5,14,31,64,129,258
    run_poly(2'b10, 12'h180, {12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5}, 24'h000102,
             1'b0, 2'b00, 3'd0, 12'd0, 1'b0);

    // Backpressure: response holds for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", 32'(rsp_data), 32'h102);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end

    // Release with a MAC beat already waiting; it is taken the cycle after
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 2'b00; req_x = 12'd2; req_y = 12'd3; req_z = 24'h10; req_last = 1'b0;
    tick();
    rsp_ready = 1'b0;
    chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_not_taken", 32'(uno_x), 32'd0);
    tick();
    chk("mac1_x", 32'(uno_x), 32'd2);
    chk("mac1_y", 32'(uno_y), 32'd3);
    chk("mac1_z", 32'(uno_z), 32'h10);
    chk("mac1_acc_en", 32'(uno_acc_en), 32'd0);
    chk("mac1_op", 32'(uno_op), 32'd0);
    chk("stream_ready", 32'(req_ready), 32'd1);
    req_x = 12'd4; req_y = 12'd5; req_op = 2'b11;
    tick();
    chk("mac2_x", 32'(uno_x), 32'd4);
    chk("mac2_y", 32'(uno_y), 32'd5);
    chk("mac2_z", 32'(uno_z), 32'd0);
    chk("mac2_acc_en", 32'(uno_acc_en), 32'd1);
    chk("mac2_op", 32'(uno_op), 32'd0);
    req_valid = 1'b0;
    tick();
    chk("bubble_x", 32'(uno_x), 32'd0);
    chk("bubble_acc_en", 32'(uno_acc_en), 32'd1);
    req_valid = 1'b1; req_op = 2'b00; req_x = 12'd1; req_y = 12'd1; req_last = 1'b1;
    tick();
    req_valid = 1'b0; req_last = 1'b0; req_z = '0;
    chk("mac3_x", 32'(uno_x), 32'd1);
    chk("mac3_acc_en", 32'(uno_acc_en), 32'd1);
    chk("mac3_z", 32'(uno_z), 32'd0);
    chk("mac_last_ready", 32'(req_ready), 32'd0);
    tick();
    chk("mac_drain_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    chk("mac_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mac_rsp_data", 32'(rsp_data), 32'h2B);
    release_rsp();

    // Log table write during a log op is rejected
    run_poly(2'b11, 12'h001, 72'd0, 24'd0, 1'b1, 2'b11, 3'd2, 12'h055, 1'b1);
    release_rsp();
    // Same write during a div op is accepted
    run_poly(2'b01, 12'h002, 72'd0, 24'd0, 1'b1, 2'b11, 3'd2, 12'h055, 1'b0);
    release_rsp();
    // Log now sees 0x55 at k=2: 0,0,0x55,0xAA,0x154,0x2A8
    run_poly(2'b11, 12'h001, {12'd0, 12'd0, 12'd0, 12'h055, 12'd0, 12'd0}, 24'h0002A8,
             1'b0, 2'b00, 3'd0, 12'd0, 1'b0);
    release_rsp();

    // Out-of-range index and op 00 are rejected
    cfg_we = 1'b1; cfg_op = 2'b10; cfg_idx = 3'd7; cfg_data = 12'h099;
    tick();
    cfg_we = 1'b0;
    chk("cfg_idx7_err", 32'(cfg_err), 32'd1);
    tick();
    chk("cfg_err_pulse_end", 32'(cfg_err), 32'd0);
    cfg_we = 1'b1; cfg_op = 2'b00; cfg_idx = 3'd1;
    tick();
    cfg_we = 1'b0;
    chk("cfg_op0_err", 32'(cfg_err), 32'd1);

    // Write and request for exp in the same IDLE cycle: new value used at k=0
    cfg_we = 1'b1; cfg_op = 2'b10; cfg_idx = 3'd4; cfg_data = 12'd9;
    req_valid = 1'b1; req_op = 2'b10; req_x = 12'h180;
    tick();
    cfg_we = 1'b0; req_valid = 1'b0;
    chk("simul_cfg_ok", 32'(cfg_err), 32'd0);
    tick();
    chk("simul_coeff_k0", 32'(uno_coeff), 32'd9);
    chk("simul_first", 32'(uno_first_cycle), 32'd1);
    tick();
    chk("simul_coeff_k1", 32'(uno_coeff), 32'd4);
    tick();
    chk("simul_coeff_k2", 32'(uno_coeff), 32'd3);

    // Reset at k=2 abandons the op
    rst_n = 1'b0;
    tick();
    chk("midrst_uno_op", 32'(uno_op), 32'd0);
    chk("midrst_coeff", 32'(uno_coeff), 32'd0);
    chk("midrst_x", 32'(uno_x), 32'd0);
    chk("midrst_first_last", {30'd0, uno_first_cycle, uno_last_cycle}, 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("postrst_ready", 32'(req_ready), 32'd1);
    chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    chk("postrst_no_rsp2", 32'(rsp_valid), 32'd0);
    // Tables cleared: exp and log both walk zeros
    run_poly(2'b10, 12'h001, 72'd0, 24'd0, 1'b0, 2'b00, 3'd0, 12'd0, 1'b0);
    release_rsp();
    run_poly(2'b11, 12'h001, 72'd0, 24'd0, 1'b0, 2'b00, 3'd0, 12'd0, 1'b0);
    release_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
